frame_update_scheduler: RTL and testbench

Per-frame sequencer for the game-logic datapath. On each vertical-blank `frame_tick` it runs a fixed, ordered list of update stages (controller sample, movement FSMs, collision, animation, etc.) through a start/done handshake, then issues one `frame_commit` pulse. The pixel pipeline uses `frame_commit` to latch the new sprite positions and animation offsets, so it never sees a half-updated frame. The block also detects frame overruns and stalled stages.

---
 rtl/frame_update_scheduler_if.sv | 27 ++
 rtl/frame_update_scheduler.sv | 169 ++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_update_scheduler_if.sv
// Handshake bundle between the frame sequencer and its update stages / pixel pipeline.
interface frame_update_scheduler_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  frame_tick;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  clear_flags;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_abort;
  logic                  frame_commit;
  logic                  busy;
  logic [15:0]           frame_count;
  logic [7:0]            overrun_count;
  logic [NUM_STAGES-1:0] timeout_flags;

  modport master (
    output frame_tick, stage_done, clear_flags,
    input  stage_start, stage_abort, frame_commit, busy,
           frame_count, overrun_count, timeout_flags
  );

  modport slave (
    input  frame_tick, stage_done, clear_flags,
    output stage_start, stage_abort, frame_commit, busy,
           frame_count, overrun_count, timeout_flags
  );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame stage sequencer: start/done handshake per stage, then one commit pulse.
// Optional per-stage watchdog enabled by defining FRAME_SCHED_TIMEOUT_EN.
module frame_update_scheduler #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  frame_update_scheduler_if.slave io_sched
);

  localparam int unsigned IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned LAST_IDX = NUM_STAGES - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [NUM_STAGES-1:0] w_idx_onehot;
  logic                  w_done_sel;
  logic                  w_expire;
  logic                  w_adv;

  logic [NUM_STAGES-1:0] r_stage_start;
  logic [NUM_STAGES-1:0] w_stage_start_nxt;
  logic                  r_frame_commit;
  logic                  w_frame_commit_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic [15:0]           r_frame_count;
  logic [7:0]            r_overrun_count;
  logic                  w_overrun;

  // Only the pending stage's done bit is observed.
  assign w_idx_onehot = NUM_STAGES'(1) << r_idx;
  assign w_done_sel   = |(io_sched.stage_done & w_idx_onehot);
  assign w_adv        = w_done_sel | w_expire;
  assign w_overrun    = io_sched.frame_tick && (r_state != S_IDLE);

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_stage_start  <= '0;
      r_frame_commit <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_stage_start  <= w_stage_start_nxt;
      r_frame_commit <= w_frame_commit_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (io_sched.frame_tick) begin
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_adv) begin
          if (r_idx == IDX_W'(LAST_IDX)) begin
            w_state_nxt = S_COMMIT;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_START;
          end
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stage_start_nxt  = '0;
    w_frame_commit_nxt = 1'b0;
    w_busy_nxt         = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_START) begin
      w_stage_start_nxt = NUM_STAGES'(1) << w_idx_nxt;
    end
    if (w_state_nxt == S_COMMIT) begin
      w_frame_commit_nxt = 1'b1;
    end
  end

  // Frame and overrun counters; a same-cycle increment beats clear_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count   <= '0;
      r_overrun_count <= '0;
    end else begin
      if (r_state == S_COMMIT) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_overrun) begin
        if (io_sched.clear_flags) begin
          r_overrun_count <= 8'd1;
        end else if (r_overrun_count != 8'hFF) begin
          r_overrun_count <= r_overrun_count + 8'd1;
        end
      end else if (io_sched.clear_flags) begin
        r_overrun_count <= '0;
      end
    end
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0]      r_wdog;
  logic [NUM_STAGES-1:0] r_timeout_flags;
  logic [NUM_STAGES-1:0] r_stage_abort;
  logic [NUM_STAGES-1:0] w_flag_set;

  assign w_expire   = (r_state == S_WAIT) && !w_done_sel && (r_wdog == CNT_W'(TIMEOUT - 1));
  assign w_flag_set = w_expire ? w_idx_onehot : '0;

  // Watchdog counts WAIT cycles without done; the abort pulse lands on the advance cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog          <= '0;
      r_timeout_flags <= '0;
      r_stage_abort   <= '0;
    end else begin
      if (r_state == S_START) begin
        r_wdog <= '0;
      end else if ((r_state == S_WAIT) && !w_done_sel) begin
        r_wdog <= r_wdog + CNT_W'(1);
      end
      r_stage_abort <= w_flag_set;
      if (io_sched.clear_flags) begin
        r_timeout_flags <= w_flag_set;
      end else begin
        r_timeout_flags <= r_timeout_flags | w_flag_set;
      end
    end
  end

  assign io_sched.timeout_flags = r_timeout_flags;
  assign io_sched.stage_abort   = r_stage_abort;
`else
  assign w_expire               = 1'b0;
  assign io_sched.timeout_flags = '0;
  assign io_sched.stage_abort   = '0;
`endif

  assign io_sched.stage_start   = r_stage_start;
  assign io_sched.frame_commit  = r_frame_commit;
  assign io_sched.busy          = r_busy;
  assign io_sched.frame_count   = r_frame_count;
  assign io_sched.overrun_count = r_overrun_count;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: directed steps plus random frames against a
// cycle-arithmetic reference model (start/commit/abort times from stage latencies).
module tb_frame_update_scheduler;

  localparam int unsigned NS    = 4;
  localparam int          TB_TO = 8;
`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  frame_update_scheduler_if #(.NUM_STAGES(NS)) sif ();

  frame_update_scheduler #(.NUM_STAGES(NS), .TIMEOUT(TB_TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sched (sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference-model state
  int          m_fc  = 0;
  int          m_ovr = 0;
  logic [NS-1:0] m_flags = '0;

  // Stage responder configuration (lat 0 = never answers)
  int          lat [NS];
  logic [NS-1:0] force_hi = '0;
  bit          noise_en = 1'b0;
  logic [NS-1:0] done_drv = '0;
  int          due [NS];
  bit          armed [NS];

  int q_st_stage[$], q_st_cyc[$], q_cm_cyc[$], q_ab_stage[$], q_ab_cyc[$];

  assign sif.stage_done = done_drv | force_hi;

  // Stage responder and output logger, working on the falling edge.
  always @(negedge clk) begin
    logic [NS-1:0] d;
    d = '0;
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        armed[k] = 1'b0;
        due[k]   = -1;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (armed[k] && due[k] == cyc) begin
          d[k]     = 1'b1;
          armed[k] = 1'b0;
        end else if (noise_en && !armed[k] && ($urandom_range(0, 3) == 0)) begin
          d[k] = 1'b1;
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (sif.stage_start[k] === 1'b1) begin
          q_st_stage.push_back(k);
          q_st_cyc.push_back(cyc);
          armed[k] = 1'b1;
          due[k]   = (lat[k] > 0) ? cyc + lat[k] : -1;
        end
        if (sif.stage_abort[k] === 1'b1) begin
          q_ab_stage.push_back(k);
          q_ab_cyc.push_back(cyc);
        end
      end
      if (sif.frame_commit === 1'b1) q_cm_cyc.push_back(cyc);
    end
    done_drv = d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int act[$], input int exp[$]);
    chk({tag, "_n"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(act[i]), 32'(exp[i]));
  endtask

  task automatic clear_logs();
    q_st_stage.delete(); q_st_cyc.delete(); q_cm_cyc.delete();
    q_ab_stage.delete(); q_ab_cyc.delete();
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frame_count"}, 32'(sif.frame_count), 32'(m_fc));
    chk({tag, "_overrun"}, 32'(sif.overrun_count), 32'(m_ovr));
    chk({tag, "_flags"}, 32'(sif.timeout_flags), 32'(m_flags));
  endtask

  // mode: 0 no extra ticks, 1 random ticks, 2 ticks at t+10 and on commit, 3 tick+clear at t+3
  task automatic run_frame(input int mode, input string tag);
    int t, s, eff, commit;
    bit tk, cl;
    int es_stage[$], es_cyc[$], ec[$], ea_stage[$], ea_cyc[$];
    logic [NS-1:0] fl;
    clear_logs();
    @(negedge clk);
    t = cyc;
    sif.frame_tick = 1'b1;
    s  = t + 1;
    fl = '0;
    for (int k = 0; k < NS; k++) begin
      es_stage.push_back(k);
      es_cyc.push_back(s);
      if (TO_EN && (lat[k] == 0 || lat[k] > TB_TO)) begin
        eff   = TB_TO;
        fl[k] = 1'b1;
        ea_stage.push_back(k);
        ea_cyc.push_back(s + TB_TO + 1);
      end else begin
        eff = lat[k];
      end
      s = s + eff + 1;
    end
    commit = s;
    ec.push_back(commit);
    for (int c = t + 1; c <= commit; c++) begin
      @(negedge clk);
      tk = 1'b0;
      cl = 1'b0;
      case (mode)
        1: tk = ($urandom_range(0, 3) == 0);
        2: tk = (c == t + 10) || (c == commit);
        3: begin tk = (c == t + 3); cl = tk; end
        default: tk = 1'b0;
      endcase
      sif.frame_tick  = tk;
      sif.clear_flags = cl;
      if (cl) m_flags = '0;
      if (tk) m_ovr = cl ? 1 : ((m_ovr < 255) ? m_ovr + 1 : 255);
      if (c == t + 1) chk({tag, "_busy_rise"}, 32'(sif.busy), 32'd1);
    end
    @(negedge clk);
    sif.frame_tick  = 1'b0;
    sif.clear_flags = 1'b0;
    chk({tag, "_busy_fall"}, 32'(sif.busy), 32'd0);
    m_fc++;
    m_flags = m_flags | fl;
    @(negedge clk);
    cmp_q({tag, "_start_stage"}, q_st_stage, es_stage);
    cmp_q({tag, "_start_cyc"}, q_st_cyc, es_cyc);
    cmp_q({tag, "_commit_cyc"}, q_cm_cyc, ec);
    cmp_q({tag, "_abort_stage"}, q_ab_stage, ea_stage);
    cmp_q({tag, "_abort_cyc"}, q_ab_cyc, ea_cyc);
    chk_counters(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
    chk({tag, "_start"}, 32'(sif.stage_start), 32'd0);
    chk({tag, "_abort"}, 32'(sif.stage_abort), 32'd0);
    chk({tag, "_commit"}, 32'(sif.frame_commit), 32'd0);
    chk_counters(tag);
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  initial begin
    sif.frame_tick  = 1'b0;
    sif.clear_flags = 1'b0;
    set_lat(3, 3, 3, 3);

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, "nominal");
    run_frame(2, "overrun");

    // Bit 3 held high while stage 1 is pending; stage 3 then completes on its first WAIT cycle
    force_hi = 4'b1000;
    set_lat(2, 5, 2, 1);
    run_frame(0, "wrong_stage");
    force_hi = '0;

    set_lat(2, 2, 2, 2);
    run_frame(3, "clear_vs_tick");

`ifdef FRAME_SCHED_TIMEOUT_EN
    set_lat(2, 2, 0, 2);
    run_frame(0, "wdog_stall");
    @(negedge clk); sif.clear_flags = 1'b1;
    @(negedge clk); sif.clear_flags = 1'b0;
    m_flags = '0; m_ovr = 0;
    @(negedge clk);
    chk_counters("wdog_clear");
    set_lat(2, 2, TB_TO, 2);
    run_frame(0, "wdog_edge_done");
`endif

    // Random latencies, stray done bits on idle stages, random overrun ticks
    noise_en = 1'b1;
    for (int f = 0; f < 15; f++) begin
      for (int k = 0; k < NS; k++) begin
        if (TO_EN && ($urandom_range(0, 3) == 0)) lat[k] = TB_TO + int'($urandom_range(0, 2));
        else lat[k] = int'($urandom_range(1, 5));
      end
      run_frame(1, $sformatf("rand%0d", f));
    end
    noise_en = 1'b0;

    // Asynchronous reset in the middle of stage 1 WAIT
    set_lat(2, 0, 2, 2);
    clear_logs();
    @(negedge clk); sif.frame_tick = 1'b1;
    @(negedge clk); sif.frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(sif.busy), 32'd1);
    #2 rst_n = 1'b0;
    m_fc = 0; m_ovr = 0; m_flags = '0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_commit_after_reset", 32'(q_cm_cyc.size()), 32'd0);
    set_lat(1, 1, 1, 1);
    run_frame(0, "post_reset");

`ifndef FRAME_SCHED_TIMEOUT_EN
    // Stall stage 0 and flood ticks to saturate the overrun counter
    set_lat(0, 1, 1, 1);
    clear_logs();
    @(negedge clk); sif.frame_tick = 1'b1;
    repeat (300) @(negedge clk);
    sif.frame_tick = 1'b0;
    m_ovr = 255;
    @(negedge clk);
    chk("sat_overrun", 32'(sif.overrun_count), 32'd255);
    sif.frame_tick = 1'b1; sif.clear_flags = 1'b1;
    @(negedge clk);
    sif.frame_tick = 1'b0; sif.clear_flags = 1'b0;
    @(negedge clk);
    chk("sat_clear_tick", 32'(sif.overrun_count), 32'd1);
    sif.clear_flags = 1'b1;
    @(negedge clk); sif.clear_flags = 1'b0;
    @(negedge clk);
    chk("sat_clear_only", 32'(sif.overrun_count), 32'd0);
    chk("sat_still_busy", 32'(sif.busy), 32'd1);
    chk("sat_no_commit", 32'(q_cm_cyc.size()), 32'd0);
    #2 rst_n = 1'b0;
    m_fc = 0; m_ovr = 0; m_flags = '0;
    @(negedge clk); rst_n = 1'b1;
    set_lat(1, 2, 3, 4);
    run_frame(0, "post_sat");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
